// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   tx_state_t  : transmitter FSM states
//   DATA_BITS, STOP_BITS, FRAME_BITS : frame geometry
//   parity_bit(): parity over one data byte, even or odd
package uart_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned STOP_BITS  = 2;
  localparam int unsigned FRAME_BITS = 1 + DATA_BITS + 1 + STOP_BITS;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } tx_state_t;

  // even=1: XOR of the data bits; even=0: its inverse.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data,
                                      input logic                 even);
    return (^data) ^ ~even;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte buffer in front of the UART transmitter.
//   i_Clock, i_Reset_n : clock, asynchronous active-low reset
//   push, push_data    : write strobe and data (ignored while full)
//   pop, pop_data      : read strobe (ignored while empty), head entry
//   full, empty, count : occupancy status, count is 0..DEPTH
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_Clock,
  input  logic             i_Reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [4:0]       count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [4:0]       count_q;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == 5'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 5'd1;
        2'b01:   count_q <= count_q - 5'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge i_Clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx.sv
// Buffered UART transmitter: start, 8 data LSB first, parity, 2 stop bits.
//   i_Clock, i_Reset_n : clock, asynchronous active-low reset
//   i_TX_DV, i_TX_Byte : byte strobe and data, accepted while o_TX_Ready
//   o_TX_Ready         : FIFO not full
//   o_TX_Serial        : registered serial line, idles high
//   o_TX_Active        : frame on the line
//   o_TX_Done          : one-cycle pulse at frame end
//   o_FIFO_Count       : bytes waiting in the FIFO
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 500,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter bit          PARITY_EVEN  = 1'b1
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Ready,
  output logic       o_TX_Serial,
  output logic       o_TX_Active,
  output logic       o_TX_Done,
  output logic [4:0] o_FIFO_Count
);

  localparam int unsigned   CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

  tx_state_t            state_q, state_d;
  logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 serial_q, active_q, done_q;
  logic                 done_d, line_bit, bit_end, pop;
  logic                 fifo_full, fifo_empty;
  logic [7:0]           fifo_data;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .i_Clock   (i_Clock),
    .i_Reset_n (i_Reset_n),
    .push      (i_TX_DV),
    .push_data (i_TX_Byte),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (o_FIFO_Count)
  );

  assign bit_end = (clk_cnt_q == LAST_CLK);

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    done_d    = 1'b0;
    line_bit  = 1'b1;

    if (state_q != IDLE) clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_d   = fifo_data;
          clk_cnt_d = '0;
          state_d   = START;
        end
      end
      START: begin
        line_bit = 1'b0;
        if (bit_end) begin
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        line_bit = shift_q[bit_idx_q];
        if (bit_end) begin
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        line_bit = parity_bit(shift_q, PARITY_EVEN);
        if (bit_end) state_d = STOP1;
      end
      STOP1: begin
        if (bit_end) state_d = STOP2;
      end
      STOP2: begin
        if (bit_end) begin
          done_d = 1'b1;
          // Chain straight into the next frame when data is waiting.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_data;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line and status are registered from the current state, so they trail
  // the FSM by one cycle and stay mutually aligned.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      serial_q  <= line_bit;
      active_q  <= (state_q != IDLE);
      done_q    <= done_d;
    end
  end

  assign o_TX_Serial = serial_q;
  assign o_TX_Active = active_q;
  assign o_TX_Done   = done_q;
  assign o_TX_Ready  = !fifo_full;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dv;
  logic [7:0] tx_byte;

  logic       ready_e, serial_e, active_e, done_e;
  logic [4:0] count_e;
  logic       ready_o, serial_o, active_o, done_o;
  logic [4:0] count_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_tx #(
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (4),
    .PARITY_EVEN  (1'b1)
  ) u_even (
    .i_Clock      (clk),
    .i_Reset_n    (rst_n),
    .i_TX_DV      (dv),
    .i_TX_Byte    (tx_byte),
    .o_TX_Ready   (ready_e),
    .o_TX_Serial  (serial_e),
    .o_TX_Active  (active_e),
    .o_TX_Done    (done_e),
    .o_FIFO_Count (count_e)
  );

  uart_tx #(
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (4),
    .PARITY_EVEN  (1'b0)
  ) u_odd (
    .i_Clock      (clk),
    .i_Reset_n    (rst_n),
    .i_TX_DV      (dv),
    .i_TX_Byte    (tx_byte),
    .o_TX_Ready   (ready_o),
    .o_TX_Serial  (serial_o),
    .o_TX_Active  (active_o),
    .o_TX_Done    (done_o),
    .o_FIFO_Count (count_o)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    dv      = 1'b1;
    tx_byte = b;
    @(negedge clk);
    dv      = 1'b0;
  endtask

  // Returns on the first negedge with the line low, bounded.
  task automatic wait_fall(input string tag);
    int n = 0;
    while (serial_e !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_fall"}, {7'd0, serial_e}, 8'd0);
  endtask

  // Entered on negedge 'off' of a frame (offset 0 = first negedge with the
  // start bit on the line); leaves on offset 47. Bits sampled mid-bit.
  task automatic check_frame(input logic [7:0] b, input logic pe, input logic po,
                             input int off, input string tag);
    logic [11:0] f;
    f = {2'b11, pe, b, 1'b0};
    for (int i = off; i < 48; i++) begin
      if (i != off) @(negedge clk);
      if (i == 0) chk($sformatf("%s_act0", tag), {7'd0, active_e}, 8'd1);
      if (i % 4 == 1) begin
        chk($sformatf("%s_bit%0d", tag, i / 4), {7'd0, serial_e}, {7'd0, f[i / 4]});
        chk($sformatf("%s_act%0d", tag, i / 4), {7'd0, active_e}, 8'd1);
        if (i / 4 == 9) chk($sformatf("%s_oddpar", tag), {7'd0, serial_o}, {7'd0, po});
      end
      if (i == 46) chk($sformatf("%s_done_early", tag), {7'd0, done_e}, 8'd0);
      if (i == 47) chk($sformatf("%s_done", tag), {7'd0, done_e}, 8'd1);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ser"},  {7'd0, serial_e}, 8'd1);
    chk({tag, "_act"},  {7'd0, active_e}, 8'd0);
    chk({tag, "_done"}, {7'd0, done_e},   8'd0);
    chk({tag, "_cnt"},  {3'd0, count_e},  8'd0);
  endtask

  logic [7:0] burst   [6] = '{8'h01, 8'h22, 8'h37, 8'h44, 8'h80, 8'h66};
  logic [4:0] burst_c [6] = '{5'd1, 5'd1, 5'd2, 5'd3, 5'd4, 5'd4};
  logic       burst_r [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic       saw_low, saw_act;

  initial begin
    rst_n   = 1'b0;
    dv      = 1'b0;
    tx_byte = 8'h00;
    repeat (2) @(negedge clk);
    check_idle("rst");
    chk("rst_ready", {7'd0, ready_e}, 8'd1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("post_rst");

    // Single frame 0xA5 with edge-accurate latency.
    push(8'hA5);
    chk("lat_cnt1", {3'd0, count_e}, 8'd1);
    chk("lat_ser1", {7'd0, serial_e}, 8'd1);
    @(negedge clk);
    chk("lat_cnt0", {3'd0, count_e}, 8'd0);
    chk("lat_ser2", {7'd0, serial_e}, 8'd1);
    @(negedge clk);
    chk("lat_fall", {7'd0, serial_e}, 8'd0);
    check_frame(8'hA5, 1'b0, 1'b1, 0, "a5");
    repeat (2) @(negedge clk);
    check_idle("a5_end");

    // Parity: 0x07 has three ones.
    push(8'h07);
    wait_fall("p07");
    check_frame(8'h07, 1'b1, 1'b0, 0, "p07");
    repeat (2) @(negedge clk);
    check_idle("p07_end");

    // Three queued bytes, sent back to back.
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    wait_fall("lb");
    check_frame(8'h00, 1'b0, 1'b1, 0, "lb00");
    @(negedge clk);
    check_frame(8'hFF, 1'b0, 1'b1, 0, "lbFF");
    @(negedge clk);
    check_frame(8'h3C, 1'b0, 1'b1, 0, "lb3C");
    repeat (2) @(negedge clk);
    check_idle("lb_end");

    // Six pushes on consecutive edges: one pop frees a slot, the sixth drops.
    for (int k = 0; k < 6; k++) begin
      dv      = 1'b1;
      tx_byte = burst[k];
      @(negedge clk);
      chk($sformatf("burst_cnt%0d", k), {3'd0, count_e}, {3'd0, burst_c[k]});
      chk($sformatf("burst_rdy%0d", k), {7'd0, ready_e}, {7'd0, burst_r[k]});
      if (k == 2) chk("burst_fall", {7'd0, serial_e}, 8'd0);
    end
    dv = 1'b0;
    check_frame(8'h01, 1'b1, 1'b0, 3, "b01");
    @(negedge clk);
    check_frame(8'h22, 1'b0, 1'b1, 0, "b22");
    @(negedge clk);
    check_frame(8'h37, 1'b1, 1'b0, 0, "b37");
    @(negedge clk);
    check_frame(8'h44, 1'b0, 1'b1, 0, "b44");
    @(negedge clk);
    check_frame(8'h80, 1'b1, 1'b0, 0, "b80");
    saw_low = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (serial_e !== 1'b1) saw_low = 1'b1;
    end
    chk("no_sixth_frame", {7'd0, saw_low}, 8'd0);
    check_idle("burst_end");

    // Reset in the middle of DATA with two bytes still queued.
    push(8'h81);
    push(8'h42);
    push(8'h24);
    wait_fall("rm");
    chk("rm_cnt", {3'd0, count_e}, 8'd2);
    repeat (9) @(negedge clk);
    chk("rm_data_bit1", {7'd0, serial_e}, 8'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("rm_async_ser", {7'd0, serial_e}, 8'd1);
    chk("rm_async_cnt", {3'd0, count_e},  8'd0);
    chk("rm_async_act", {7'd0, active_e}, 8'd0);
    chk("rm_async_rdy", {7'd0, ready_e},  8'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_low = 1'b0;
    saw_act = 1'b0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (serial_e !== 1'b1) saw_low = 1'b1;
      if (active_e !== 1'b0) saw_act = 1'b1;
    end
    chk("rm_no_frame", {7'd0, saw_low}, 8'd0);
    chk("rm_no_active", {7'd0, saw_act}, 8'd0);
    check_idle("rm_idle");

    push(8'hC3);
    wait_fall("c3");
    check_frame(8'hC3, 1'b0, 1'b1, 0, "c3");
    repeat (2) @(negedge clk);
    check_idle("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 500, clocks per serial bit (i_Clock frequency / baud).
REQ-002 Parameter FIFO_DEPTH, default 4, byte-buffer entries; SHALL be a power of two, 2 to 16.
REQ-003 Parameter PARITY_EVEN, default 1; 1 = even parity, 0 = odd parity.
REQ-004 i_Clock  in  1  sole clock; all state changes on its rising edge.
REQ-005 i_Reset_n  in  1  reset, asynchronous, active-low.
REQ-006 i_TX_DV  in  1  byte-valid strobe.
REQ-007 i_TX_Byte  in  8  byte to send; sampled when accepted.
REQ-008 o_TX_Ready  out  1  high while the FIFO is not full.
REQ-009 o_TX_Serial  out  1  serial line; idles high.
REQ-010 o_TX_Active  out  1  high while a frame is on the line.
REQ-011 o_TX_Done  out  1  one-cycle pulse at frame end.
REQ-012 o_FIFO_Count  out  5  current FIFO occupancy, 0..FIFO_DEPTH.

Function
REQ-013 Frame format SHALL be: 1 start bit (0), 8 data bits LSB first, 1 parity bit, 2 stop bits (1); 12 bits total.
REQ-014 Each bit SHALL be held for exactly CLKS_PER_BIT cycles, so a frame lasts 12*CLKS_PER_BIT cycles.
REQ-015 The parity bit SHALL be computed as follows: with PARITY_EVEN=1 it is the XOR of the 8 data bits; with PARITY_EVEN=0 it is the inverse of that XOR.
REQ-016 A byte SHALL be accepted on any rising edge where i_TX_DV=1 and o_TX_Ready=1; if i_TX_DV=1 while the FIFO is full, the byte is dropped and state is unchanged.
REQ-017 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP1 and STOP2, with transitions as follows:
- IDLE to START when the FIFO is not empty; the head byte is popped into the shift register on this transition.
- START to DATA to PARITY to STOP1 to STOP2, each after its bit time; DATA uses a 3-bit index running 0..7.
REQ-018 At the end of STOP2, the FSM SHALL go to START with an immediate pop if the FIFO is not empty, and to IDLE otherwise, so back-to-back frames have no idle gap.
REQ-019 Latency: for a byte accepted at edge N into an empty FIFO with the FSM in IDLE, o_TX_Serial SHALL fall at edge N+2.
REQ-020 A push and a pop on the same edge SHALL both take effect, leaving o_FIFO_Count unchanged; a pop from an empty FIFO SHALL never occur.
REQ-021 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; o_FIFO_Count SHALL be exact at the full and empty boundaries.
REQ-022 o_TX_Done SHALL pulse high for one cycle on the edge that ends STOP2.
REQ-023 o_TX_Active SHALL be high from the first START cycle through the last STOP2 cycle, and SHALL remain high across back-to-back frames.
REQ-024 The bit-time counter width SHALL be $clog2(CLKS_PER_BIT) bits so that no truncation occurs.
REQ-025 o_TX_Serial SHALL be registered with no combinational path from inputs.

Reset
REQ-026 While i_Reset_n=0, the block SHALL hold: o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, o_TX_Ready=1, o_FIFO_Count=0, FSM in IDLE, pointers and counters at 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame and discard all FIFO contents; the line SHALL return high asynchronously, without waiting for a clock edge.
REQ-028 After reset deasserts, no frame SHALL start until a new byte is accepted.

Structure
REQ-029 Shared package uart_pkg SHALL hold:
- the TX state enum;
- frame constants: DATA_BITS=8, STOP_BITS=2, FRAME_BITS=12;
- the parity helper function.
REQ-030 The FIFO SHALL be a separate sub-module, uart_tx_fifo, parameterised by depth and width 8, with push/pop/full/empty/count ports and the same clock and reset.

Verification
REQ-031 With CLKS_PER_BIT=4, sending 0xA5 SHALL produce the line bits 0,1,0,1,0,0,1,0,1,0,1,1, each held 4 cycles, with o_TX_Done pulsing at the 48th cycle after the line falls.
REQ-032 With PARITY_EVEN=1, sending 0x07 SHALL give parity bit 1; with PARITY_EVEN=0, sending 0x07 SHALL give parity bit 0.
REQ-033 With FIFO_DEPTH=4 and the FSM in IDLE, pushing 6 bytes on consecutive edges SHALL accept 5, reject the 6th with o_TX_Ready=0, and transmit 5 contiguous frames with o_TX_Active held high throughout.
REQ-034 Looping back into the team's receiver (same CLKS_PER_BIT, 9 data bits) with bytes 0x00, 0xFF and 0x3C SHALL deliver each byte on its 8-bit output with the correct 9th (parity) bit.
REQ-035 Asserting i_Reset_n=0 in the middle of DATA with 2 bytes queued SHALL drive o_TX_Serial to 1 before the next edge and zero o_FIFO_Count, and after release SHALL produce no frame until a new push.
